// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for three requesters with a busy-bit scoreboard.
// Optional RF_WB_BYPASS_EN adds bypass outputs and hazard suppression on a commit.
module rf_wb_arbiter #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       req_valid,
   input  logic [3*AW-1:0]  req_addr,
   input  logic [3*WIDTH-1:0] req_data,
   output logic [2:0]       req_ready,
   input  logic             alloc_valid,
   input  logic [AW-1:0]    alloc_reg,
   input  logic [AW-1:0]    rd_reg1,
   input  logic [AW-1:0]    rd_reg2,
   output logic             rd_hazard1,
   output logic             rd_hazard2,
`ifdef RF_WB_BYPASS_EN
   output logic             byp_valid1,
   output logic             byp_valid2,
   output logic [WIDTH-1:0] byp_data1,
   output logic [WIDTH-1:0] byp_data2,
`endif
   output logic             we_1,
   output logic [AW-1:0]    write_reg1,
   output logic [WIDTH-1:0] write_reg1_data,
   output logic             err_sticky
);

   logic [1:0]       ptr;
   logic [2:0]       grant;
   logic [1:0]       win_idx;
   logic             xfer;
   logic [AW-1:0]    win_addr;
   logic [WIDTH-1:0] win_data;
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;

   // Search starts at ptr and wraps through the three requesters.
   always_comb begin
      logic found;
      int   idx;
      grant   = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         idx = (int'(ptr) + k) % 3;
         if (!found && req_valid[idx]) begin
            found        = 1'b1;
            grant[idx]   = 1'b1;
            win_idx      = 2'(idx);
         end
      end
   end

   assign req_ready = rst_n ? grant : 3'b000;
   assign xfer      = |(req_valid & req_ready);
   assign win_addr  = req_addr[win_idx*AW +: AW];
   assign win_data  = req_data[win_idx*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr             <= '0;
         we_1            <= 1'b0;
         write_reg1      <= '0;
         write_reg1_data <= '0;
      end else begin
         we_1 <= xfer && (win_addr != '0);
         if (xfer) begin
            ptr             <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
            write_reg1      <= win_addr;
            write_reg1_data <= win_data;
         end
      end
   end

   // Clear first so a same-edge allocation of the committing register wins.
   always_comb begin
      busy_nxt = busy;
      if (we_1)
         busy_nxt[write_reg1] = 1'b0;
      if (alloc_valid && alloc_reg != '0)
         busy_nxt[alloc_reg] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= '0;
         err_sticky <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (we_1 && !busy[write_reg1])
            err_sticky <= 1'b1;
      end
   end

`ifdef RF_WB_BYPASS_EN
   logic match1, match2;
   logic kill1, kill2;

   assign match1 = we_1 && (write_reg1 == rd_reg1) && (rd_reg1 != '0);
   assign match2 = we_1 && (write_reg1 == rd_reg2) && (rd_reg2 != '0);
   assign kill1  = alloc_valid && (alloc_reg == rd_reg1);
   assign kill2  = alloc_valid && (alloc_reg == rd_reg2);

   assign byp_valid1 = match1;
   assign byp_valid2 = match2;
   assign byp_data1  = write_reg1_data;
   assign byp_data2  = write_reg1_data;

   assign rd_hazard1 = (rd_reg1 != '0) && busy[rd_reg1] && !(match1 && !kill1);
   assign rd_hazard2 = (rd_reg2 != '0) && busy[rd_reg2] && !(match2 && !kill2);
`else
   assign rd_hazard1 = (rd_reg1 != '0) && busy[rd_reg1];
   assign rd_hazard2 = (rd_reg2 != '0) && busy[rd_reg2];
`endif

endmodule
